width_16to8_buf: RTL

WIDTH_16TO8_BUF -- requirements
Module: width_16to8_buf

---
 rtl/width_conv_pkg.sv | 15 +
 rtl/width_fifo.sv | 79 +++++++
 rtl/width_16to8_buf.sv | 127 ++++++++++++
 3 files changed

// File: rtl/width_conv_pkg.sv
// width_conv_pkg
// Shared definitions for the 16-to-8 bit width converter:
//   DEFAULT_DEPTH - default number of 16-bit words held by the input FIFO
//   out_state_e   - output FSM states (IDLE: no byte, HI: high byte, LO: low byte)
package width_conv_pkg;

  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } out_state_e;

endpackage

// File: rtl/width_fifo.sv
// width_fifo
// Synchronous FIFO holding WIDTH-bit words. There is no upstream
// backpressure: a write request that arrives while the FIFO is full and no
// pop happens on the same edge is dropped and flagged on 'drop'.
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   wr_req       - request to write wr_data this edge
//   wr_data      - word to write
//   rd_en        - pop the head word this edge (ignored when empty)
//   rd_data      - current head word (meaningful only when !empty)
//   level        - number of stored words
//   empty        - level == 0
//   drop         - this edge's write request is being discarded
module width_fifo
  import width_conv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             rd_do;
  logic             wr_en;

  // Full/empty come from the level counter; a write at full is only
  // accepted when the head is leaving on the same edge.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_do   = rd_en && !empty;
  assign wr_en   = wr_req && (!full || rd_do);
  assign drop    = wr_req && full && !rd_do;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; stale entries are never read because pops are
  // only allowed when level > 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_do) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_do})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/width_16to8_buf.sv
// width_16to8_buf
// Buffers 16-bit words in a FIFO and streams them out as bytes, high byte
// first, under valid/ready handshaking on the output side.
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   valid_in    - data_in carries a word this cycle (no upstream ready)
//   data_in     - word: first byte [15:8], second byte [7:0]
//   ready_out   - downstream accepts a byte this cycle
//   valid_out   - data_out carries a byte (registered)
//   data_out    - output byte (registered)
//   level       - words stored in the FIFO
//   overflow    - sticky: a word has been dropped since reset
module width_16to8_buf
  import width_conv_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [15:0]            data_in,
  input  logic                   ready_out,
  output logic                   valid_out,
  output logic [7:0]             data_out,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  out_state_e  state;
  out_state_e  state_nxt;
  logic [15:0] hold_reg;
  logic [15:0] hold_nxt;
  logic        valid_nxt;
  logic [7:0]  data_nxt;
  logic        pop;
  logic [15:0] fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_drop;

  width_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (valid_in),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (level),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  // Next-state logic. Outputs are computed one cycle ahead so valid_out and
  // data_out leave the block straight from flops. A pop loads the holding
  // register and presents the high byte in the same edge.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_reg;
    valid_nxt = valid_out;
    data_nxt  = data_out;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = HI;
          hold_nxt  = fifo_rd_data;
          valid_nxt = 1'b1;
          data_nxt  = fifo_rd_data[15:8];
        end
      end
      HI: begin
        if (ready_out) begin
          state_nxt = LO;
          data_nxt  = hold_reg[7:0];
        end
      end
      LO: begin
        if (ready_out) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = HI;
            hold_nxt  = fifo_rd_data;
            valid_nxt = 1'b1;
            data_nxt  = fifo_rd_data[15:8];
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            data_nxt  = 8'h00;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        data_nxt  = 8'h00;
      end
    endcase
  end

  // State, holding register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_reg  <= '0;
      valid_out <= 1'b0;
      data_out  <= 8'h00;
    end else begin
      state     <= state_nxt;
      hold_reg  <= hold_nxt;
      valid_out <= valid_nxt;
      data_out  <= data_nxt;
    end
  end

  // Sticky overflow: set on any dropped word, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

endmodule
